imem_stream_loader: RTL
=======================

// Module: imem_stream_loader
// PURPOSE
//  Writer side of the mips16_sc instruction memory: receives a framed byte stream and writes
//  32-bit instruction words into instruction memory from address 0 upward.
//  Holds the CPU stalled during loading and releases it once a frame checks good.
//  Synthesizable replacement for the bench-only $readmemb preload; sits between a byte
//  source (UART/JTAG bridge) and the instruction memory write port.
// PARAMETERS
//  ADDR_W        8      instruction-memory word-address width (depth = 2**ADDR_W words)
//  SYNC_BYTE     8'hA5  frame start marker
//  HOLD_AT_RESET 1      1: cpu_hold=1 out of reset until a good load; 0: cpu_hold=0 out of reset
// PORTS
//  clock        in   1       system clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  rx_data      in   8       stream byte
//  rx_valid     in   1       rx_data valid; byte accepted when rx_valid && rx_ready
//  rx_ready     out  1       loader can accept a byte this cycle
//  imem_we      out  1       one-cycle instruction-memory write strobe
//  imem_addr    out  ADDR_W  word address for imem_we
//  imem_wdata   out  32      instruction word for imem_we
//  cpu_hold     out  1       stall/hold request to the CPU (drives instr_stall)
//  load_done    out  1       level; last frame loaded and checksum matched
//  load_error   out  1       level; last frame aborted (bad count or checksum)
//  words_loaded out  ADDR_W+1 words written by the current/last frame
// BEHAVIOUR
//  Frame: SYNC_BYTE, CNT_HI, CNT_LO, N*4 data bytes (big-endian words), CSUM.
//  N = {CNT_HI,CNT_LO}; CSUM = XOR of CNT_HI, CNT_LO and all data bytes.
//  Reset: state=IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0,
//   load_error=0, words_loaded=0, cpu_hold=HOLD_AT_RESET.
//  rx_ready is 1 in every state, so every byte is accepted in the cycle it is valid.
//  FSM on accepted bytes only; no accepted byte -> state unchanged:
//   IDLE:   byte==SYNC -> CNT_HI (clear checksum, byte counter, words_loaded; clear
//           load_done/load_error; cpu_hold=1); any other byte discarded.
//   CNT_HI: latch high count byte -> CNT_LO.
//   CNT_LO: latch low count byte. N > 2**ADDR_W -> ERROR. N==0 -> CSUM. Otherwise -> DATA.
//   DATA:   shift byte into word register (first byte = bits 31:24). On 4th byte of a word,
//           next cycle: imem_we=1 for exactly one cycle, imem_addr=word index,
//           imem_wdata=word; words_loaded increments in the same cycle.
//           After word N-1's 4th byte -> CSUM.
//   CSUM:   byte==running XOR -> DONE, else -> ERROR.
//   DONE:   load_done=1, cpu_hold=0. SYNC byte restarts as from IDLE; other bytes ignored.
//   ERROR:  load_error=1, cpu_hold stays 1. SYNC byte restarts as from IDLE; others ignored.
//  Latency: last data byte accepted -> imem_we at cycle +1. CSUM accepted -> load_done
//   and cpu_hold=0 at cycle +1.
//  A SYNC-valued byte inside CNT/DATA/CSUM is payload, not a restart.
//  Words written before an ERROR stay in memory; no rollback.
//  imem_addr wraps never: N is bounded by 2**ADDR_W, so max index = 2**ADDR_W-1.
//  Reset mid-frame: immediate return to reset values; partial word discarded.
//  No timeout: a stalled frame waits indefinitely with cpu_hold=1.
// STRUCTURE
//  loader_defs.vh: state encodings (IDLE..ERROR, 3 bits), default SYNC_BYTE, frame field
//   byte positions; shared with any bench-side frame generator.
//  One sub-module, word_assembler: 4-byte shift register, byte counter, and word_ready
//   pulse. Top level holds the FSM, count/address counters, checksum and outputs.
// TESTING
//  1 Frame A5 00 02 | 20080005 | 2009000A | csum=02^00^XOR(data bytes) -> we at addr 0,1;
//    wdata 0x20080005, 0x2009000A; load_done=1, cpu_hold=0, words_loaded=2.
//  2 Same frame with csum bit-flipped -> both writes occur; load_error=1, cpu_hold=1,
//    load_done=0.
//  3 Count 0x0101 with ADDR_W=8 -> ERROR right after CNT_LO; no imem_we pulses.
//  4 Leading garbage 00 FF 3C, then a valid 1-word frame containing data byte A5 -> garbage
//    ignored; A5 treated as payload; one write; load_done=1.
//  5 reset asserted after 2 bytes of word 1 -> all outputs at reset values the next cycle;
//    a fresh frame then loads from addr 0.
//  6 In DONE, send a new valid frame -> load_done drops, cpu_hold=1 on SYNC, new words
//    overwrite from addr 0; random rx_valid gaps do not change results.

Source files
------------

// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader: FSM encoding,
// default frame marker and byte positions of the fixed frame header.
package imem_stream_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } ldr_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Byte offsets inside a frame; data starts at FRM_DATA, CSUM follows N*4 data bytes.
  localparam int FRM_SYNC   = 0;
  localparam int FRM_CNT_HI = 1;
  localparam int FRM_CNT_LO = 2;
  localparam int FRM_DATA   = 3;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle of the loader.
interface imem_stream_loader_if #(parameter int ADDR_W = 8);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata,
           cpu_hold, load_done, load_error, words_loaded
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
           cpu_hold, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/imem_stream_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words; word_ready flags the 4th byte of a
// word combinationally so the top can register the write on the same edge.
module word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);
  logic [23:0] sr_q, sr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  assign word_next  = {sr_q, byte_in};
  assign word_ready = shift_en && (byte_cnt_q == 2'd3);

  always_comb begin
    sr_d       = sr_q;
    byte_cnt_d = byte_cnt_q;
    if (clear) begin
      sr_d       = '0;
      byte_cnt_d = '0;
    end else if (shift_en) begin
      sr_d       = {sr_q[15:0], byte_in};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q       <= '0;
      byte_cnt_q <= '0;
    end else begin
      sr_q       <= sr_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
endmodule

// File: rtl/imem_stream_loader.sv
// Framed byte-stream loader for the instruction memory: SYNC, 16-bit word count,
// big-endian words written from address 0, XOR checksum; holds the CPU until good.
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int         ADDR_W        = 8,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  imem_stream_loader_if.slave bus
);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  ldr_state_e        state_q, state_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

  logic        acc, restart, asm_clear, asm_shift, word_ready;
  logic [31:0] word_next;
  logic [16:0] n_full;
  logic [ADDR_W:0] words_inc;

  // Loader never back-pressures: every valid byte is consumed.
  assign acc       = bus.rx_valid;
  assign restart   = acc && (bus.rx_data == SYNC_BYTE);
  assign n_full    = {1'b0, cnt_hi_q, bus.rx_data};
  assign words_inc = words_loaded_q + (ADDR_W+1)'(1);

  word_assembler u_wasm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .shift_en   (asm_shift),
    .byte_in    (bus.rx_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d        = state_q;
    cnt_hi_d       = cnt_hi_q;
    cnt_d          = cnt_q;
    csum_d         = csum_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    load_done_d    = load_done_q;
    load_error_d   = load_error_q;
    words_loaded_d = words_loaded_q;
    asm_clear      = 1'b0;
    asm_shift      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (restart) begin
          state_d        = S_CNT_HI;
          csum_d         = '0;
          words_loaded_d = '0;
          load_done_d    = 1'b0;
          load_error_d   = 1'b0;
          cpu_hold_d     = 1'b1;
          asm_clear      = 1'b1;
        end
      end
      S_CNT_HI: if (acc) begin
        cnt_hi_d = bus.rx_data;
        csum_d   = csum_q ^ bus.rx_data;
        state_d  = S_CNT_LO;
      end
      S_CNT_LO: if (acc) begin
        csum_d = csum_q ^ bus.rx_data;
        cnt_d  = n_full[ADDR_W:0];
        if (n_full > MAX_N) begin
          state_d      = S_ERROR;
          load_error_d = 1'b1;
        end else if (n_full == '0) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (acc) begin
        asm_shift = 1'b1;
        csum_d    = csum_q ^ bus.rx_data;
        if (word_ready) begin
          imem_we_d      = 1'b1;
          imem_addr_d    = words_loaded_q[ADDR_W-1:0];
          imem_wdata_d   = word_next;
          words_loaded_d = words_inc;
          if (words_inc == cnt_q) state_d = S_CSUM;
        end
      end
      S_CSUM: if (acc) begin
        if (bus.rx_data == csum_q) begin
          state_d     = S_DONE;
          load_done_d = 1'b1;
          cpu_hold_d  = 1'b0;
        end else begin
          state_d      = S_ERROR;
          load_error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_hi_q       <= '0;
      cnt_q          <= '0;
      csum_q         <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_hold_q     <= HOLD_AT_RESET;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_hi_q       <= cnt_hi_d;
      cnt_q          <= cnt_d;
      csum_q         <= csum_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign bus.rx_ready     = 1'b1;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.cpu_hold     = cpu_hold_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_error   = load_error_q;
  assign bus.words_loaded = words_loaded_q;
endmodule
